// File: rtl/lottery_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : lottery_input_ctrl_if
// Board-side inputs and game-side strobes of the lottery input controller.
// Rev    : 1.0
// ============================================================================
interface lottery_input_ctrl_if;
  logic [3:0] sw;
  logic       key_insert_n;
  logic       key_finish_n;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic [2:0] digit_count;
  logic       err;
  logic       locked;

  modport master (
    output sw, key_insert_n, key_finish_n,
    input  num, insert, finish, digit_count, err, locked
  );

  modport slave (
    input  sw, key_insert_n, key_finish_n,
    output num, insert, finish, digit_count, err, locked
  );
endinterface
`default_nettype wire

// File: rtl/lottery_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lottery_input_ctrl
// Syncs/debounces switches and buttons, enforces the 5-digit entry sequence.
// Optional macro LOTTERY_DIGIT_FILTER_EN rejects digits 10..15.
// Rev    : 1.0
// ============================================================================
module lottery_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int MAX_DIGITS      = 5
) (
  input wire clk,
  input wire reset,
  lottery_input_ctrl_if.slave bus_if
);

  localparam int               C_NBTN    = 2;
  localparam int               C_INS     = 0;
  localparam int               C_FIN     = 1;
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       C_MAX     = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_FULL    = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic [C_NBTN-1:0] w_btn_raw;
  logic [C_NBTN-1:0] w_press;
  logic [1:0]        vld_q;
  logic [3:0]        sw_meta_q;
  logic [3:0]        sw_sync_q;
  logic              w_digit_ok;

  assign w_btn_raw = {bus_if.key_finish_n, bus_if.key_insert_n};

  // vld_q[1] marks that the synchroniser outputs hold real pin samples
  // rather than their reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= 2'b00;
      sw_meta_q <= 4'd0;
      sw_sync_q <= 4'd0;
    end else begin
      vld_q     <= {vld_q[0], 1'b1};
      sw_meta_q <= bus_if.sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  for (genvar gi = 0; gi < C_NBTN; gi++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic             armed_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync_q != db_q) begin
        if (cnt_q == C_DB_LAST) begin
          db_d = sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // A button found held when reset lifts must be seen released before
    // any press from it counts.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_q   <= 1'b1;
        sync_q   <= 1'b1;
        db_q     <= 1'b1;
        db_dly_q <= 1'b1;
        armed_q  <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        meta_q   <= w_btn_raw[gi];
        sync_q   <= meta_q;
        db_q     <= db_d;
        cnt_q    <= cnt_d;
        db_dly_q <= db_q;
        if (vld_q[1] && sync_q) begin
          armed_q <= 1'b1;
        end
        press_q  <= armed_q & db_dly_q & ~db_q;
      end
    end

    assign w_press[gi] = press_q;
  end

`ifdef LOTTERY_DIGIT_FILTER_EN
  assign w_digit_ok = (sw_sync_q <= 4'd9);
`else
  assign w_digit_ok = 1'b1;
`endif

  state_t     state_q, state_d;
  logic [3:0] num_q, num_d;
  logic       insert_q, insert_d;
  logic       finish_q, finish_d;
  logic       err_q, err_d;
  logic [2:0] count_q, count_d;
  logic       locked_q, locked_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_COLLECT;
      num_q    <= 4'd0;
      insert_q <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 3'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      insert_q <= insert_d;
      finish_q <= finish_d;
      err_q    <= err_d;
      count_q  <= count_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    insert_d = 1'b0;
    finish_d = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    locked_d = locked_q;
    case (state_q)
      S_COLLECT: begin
        if (w_press[C_INS]) begin
          if (w_digit_ok) begin
            num_d    = sw_sync_q;
            insert_d = 1'b1;
            count_d  = count_q + 3'd1;
            if (count_q + 3'd1 == C_MAX) begin
              state_d = S_FULL;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        // A finish before all digits is always a violation, even alongside
        // an insert that is itself accepted.
        if (w_press[C_FIN]) begin
          err_d = 1'b1;
        end
      end
      S_FULL: begin
        if (w_press[C_FIN]) begin
          finish_d = 1'b1;
          locked_d = 1'b1;
          state_d  = S_LOCKED;
        end else if (w_press[C_INS]) begin
          err_d = 1'b1;
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  assign bus_if.num         = num_q;
  assign bus_if.insert      = insert_q;
  assign bus_if.finish      = finish_q;
  assign bus_if.err         = err_q;
  assign bus_if.digit_count = count_q;
  assign bus_if.locked      = locked_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
                                  !(insert_q && finish_q));

endmodule
`default_nettype wire

// File: tb/tb_lottery_input_ctrl.sv
`default_nettype none
// Directed bench for lottery_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_lottery_input_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   ins_cnt  = 0;
  int   fin_cnt  = 0;
  int   err_cnt  = 0;
  logic both_seen = 1'b0;

  lottery_input_ctrl_if bus_if();

  lottery_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .MAX_DIGITS     (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.insert === 1'b1) ins_cnt++;
    if (bus_if.finish === 1'b1) fin_cnt++;
    if (bus_if.err === 1'b1) err_cnt++;
    if (bus_if.insert === 1'b1 && bus_if.finish === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);
  endtask

  task automatic press(input logic do_ins, input logic do_fin, input logic [3:0] d);
    bus_if.sw = d;
    tick(2);
    if (do_ins) bus_if.key_insert_n = 1'b0;
    if (do_fin) bus_if.key_finish_n = 1'b0;
    tick(12);
    bus_if.key_insert_n = 1'b1;
    bus_if.key_finish_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.sw = 4'd0;
    bus_if.key_insert_n = 1'b1;
    bus_if.key_finish_n = 1'b1;
    tick(3);
    checks++; if (bus_if.num !== 4'd0) begin failures++; $display("FAIL rst_num got=%0d exp=0", bus_if.num); end
    checks++; if (bus_if.insert !== 1'b0) begin failures++; $display("FAIL rst_insert got=%b exp=0", bus_if.insert); end
    checks++; if (bus_if.finish !== 1'b0) begin failures++; $display("FAIL rst_finish got=%b exp=0", bus_if.finish); end
    checks++; if (bus_if.digit_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus_if.digit_count); end
    checks++; if (bus_if.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus_if.err); end
    checks++; if (bus_if.locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", bus_if.locked); end
    reset = 1'b1;
    tick(5);
    checks++; if (ins_cnt + fin_cnt + err_cnt !== 0) begin failures++; $display("FAIL rst_release_strobes got=%0d exp=0", ins_cnt + fin_cnt + err_cnt); end
  endtask

  task automatic test_latency();
    int i0;
    bus_if.sw = 4'd5;
    tick(2);
    i0 = ins_cnt;
    bus_if.key_insert_n = 1'b0;
    tick(7);
    checks++; if (bus_if.insert !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", bus_if.insert); end
    tick(1);
    checks++; if (bus_if.insert !== 1'b1) begin failures++; $display("FAIL lat_strobe got=%b exp=1", bus_if.insert); end
    checks++; if (bus_if.num !== 4'd5) begin failures++; $display("FAIL lat_num got=%0d exp=5", bus_if.num); end
    checks++; if (bus_if.digit_count !== 3'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", bus_if.digit_count); end
    tick(1);
    checks++; if (bus_if.insert !== 1'b0) begin failures++; $display("FAIL lat_width got=%b exp=0", bus_if.insert); end
    tick(11);
    bus_if.key_insert_n = 1'b1;
    tick(10);
    checks++; if (ins_cnt - i0 !== 1) begin failures++; $display("FAIL lat_held_once got=%0d exp=1", ins_cnt - i0); end
  endtask

  task automatic test_bounce();
    int i0;
    bus_if.sw = 4'd3;
    tick(2);
    i0 = ins_cnt;
    for (int k = 0; k < 3; k++) begin
      bus_if.key_insert_n = 1'b0;
      tick(2);
      bus_if.key_insert_n = 1'b1;
      tick(2);
    end
    tick(8);
    checks++; if (ins_cnt - i0 !== 0) begin failures++; $display("FAIL bounce_quiet got=%0d exp=0", ins_cnt - i0); end
    bus_if.key_insert_n = 1'b0;
    tick(15);
    bus_if.key_insert_n = 1'b1;
    tick(10);
    checks++; if (ins_cnt - i0 !== 1) begin failures++; $display("FAIL bounce_single got=%0d exp=1", ins_cnt - i0); end
    checks++; if (bus_if.num !== 4'd3) begin failures++; $display("FAIL bounce_num got=%0d exp=3", bus_if.num); end
    checks++; if (bus_if.digit_count !== 3'd2) begin failures++; $display("FAIL bounce_count got=%0d exp=2", bus_if.digit_count); end
  endtask

  task automatic test_sequence();
    int i0, e0, f0;
    logic [3:0] digs [5];
    digs = '{4'd5, 4'd0, 4'd9, 4'd6, 4'd7};
    do_reset();
    i0 = ins_cnt;
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, digs[k]);
    checks++; if (ins_cnt - i0 !== 5) begin failures++; $display("FAIL seq_inserts got=%0d exp=5", ins_cnt - i0); end
    checks++; if (bus_if.digit_count !== 3'd5) begin failures++; $display("FAIL seq_count got=%0d exp=5", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd7) begin failures++; $display("FAIL seq_num got=%0d exp=7", bus_if.num); end
    checks++; if (bus_if.locked !== 1'b0) begin failures++; $display("FAIL seq_unlocked got=%b exp=0", bus_if.locked); end
    e0 = err_cnt;
    i0 = ins_cnt;
    press(1'b1, 1'b0, 4'd2);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL seq_6th_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (ins_cnt - i0 !== 0) begin failures++; $display("FAIL seq_6th_ins got=%0d exp=0", ins_cnt - i0); end
    checks++; if (bus_if.num !== 4'd7) begin failures++; $display("FAIL seq_6th_num got=%0d exp=7", bus_if.num); end
    checks++; if (bus_if.digit_count !== 3'd5) begin failures++; $display("FAIL seq_6th_count got=%0d exp=5", bus_if.digit_count); end
    f0 = fin_cnt;
    press(1'b0, 1'b1, 4'd0);
    checks++; if (fin_cnt - f0 !== 1) begin failures++; $display("FAIL seq_finish got=%0d exp=1", fin_cnt - f0); end
    checks++; if (bus_if.locked !== 1'b1) begin failures++; $display("FAIL seq_locked got=%b exp=1", bus_if.locked); end
    e0 = err_cnt;
    i0 = ins_cnt;
    f0 = fin_cnt;
    press(1'b1, 1'b0, 4'd4);
    press(1'b0, 1'b1, 4'd0);
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL lock_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (ins_cnt - i0 + fin_cnt - f0 !== 0) begin failures++; $display("FAIL lock_strobes got=%0d exp=0", ins_cnt - i0 + fin_cnt - f0); end
    checks++; if (bus_if.digit_count !== 3'd5) begin failures++; $display("FAIL lock_count got=%0d exp=5", bus_if.digit_count); end
  endtask

  task automatic test_early_finish();
    int i0, e0, f0;
    do_reset();
    press(1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 4'd2);
    e0 = err_cnt;
    f0 = fin_cnt;
    press(1'b0, 1'b1, 4'd0);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL early_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (fin_cnt - f0 !== 0) begin failures++; $display("FAIL early_finish got=%0d exp=0", fin_cnt - f0); end
    checks++; if (bus_if.digit_count !== 3'd2) begin failures++; $display("FAIL early_count got=%0d exp=2", bus_if.digit_count); end
    e0 = err_cnt;
    i0 = ins_cnt;
    press(1'b1, 1'b0, 4'd12);
`ifdef LOTTERY_DIGIT_FILTER_EN
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL filt_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (ins_cnt - i0 !== 0) begin failures++; $display("FAIL filt_ins got=%0d exp=0", ins_cnt - i0); end
    checks++; if (bus_if.digit_count !== 3'd2) begin failures++; $display("FAIL filt_count got=%0d exp=2", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd2) begin failures++; $display("FAIL filt_num got=%0d exp=2", bus_if.num); end
`else
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL nofilt_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (ins_cnt - i0 !== 1) begin failures++; $display("FAIL nofilt_ins got=%0d exp=1", ins_cnt - i0); end
    checks++; if (bus_if.digit_count !== 3'd3) begin failures++; $display("FAIL nofilt_count got=%0d exp=3", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd12) begin failures++; $display("FAIL nofilt_num got=%0d exp=12", bus_if.num); end
`endif
  endtask

  task automatic test_simultaneous();
    int i0, e0, f0;
    do_reset();
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 4'(k + 1));
    i0 = ins_cnt; e0 = err_cnt; f0 = fin_cnt;
    press(1'b1, 1'b1, 4'd8);
    checks++; if (fin_cnt - f0 !== 1) begin failures++; $display("FAIL simfull_finish got=%0d exp=1", fin_cnt - f0); end
    checks++; if (ins_cnt - i0 !== 0) begin failures++; $display("FAIL simfull_ins got=%0d exp=0", ins_cnt - i0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL simfull_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (bus_if.locked !== 1'b1) begin failures++; $display("FAIL simfull_locked got=%b exp=1", bus_if.locked); end
    do_reset();
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 4'(k + 1));
    i0 = ins_cnt; e0 = err_cnt; f0 = fin_cnt;
    press(1'b1, 1'b1, 4'd8);
    checks++; if (ins_cnt - i0 !== 1) begin failures++; $display("FAIL simcol_ins got=%0d exp=1", ins_cnt - i0); end
    checks++; if (fin_cnt - f0 !== 0) begin failures++; $display("FAIL simcol_finish got=%0d exp=0", fin_cnt - f0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL simcol_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (bus_if.digit_count !== 3'd4) begin failures++; $display("FAIL simcol_count got=%0d exp=4", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd8) begin failures++; $display("FAIL simcol_num got=%0d exp=8", bus_if.num); end
  endtask

  task automatic test_reset_mid();
    int i0;
    do_reset();
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 4'(k + 2));
    bus_if.sw = 4'd4;
    tick(2);
    bus_if.key_insert_n = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    checks++; if (bus_if.digit_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd0) begin failures++; $display("FAIL mid_num got=%0d exp=0", bus_if.num); end
    checks++; if ({bus_if.insert, bus_if.finish, bus_if.err, bus_if.locked} !== 4'b0000) begin
      failures++; $display("FAIL mid_flags got=%b exp=0000", {bus_if.insert, bus_if.finish, bus_if.err, bus_if.locked});
    end
    tick(2);
    i0 = ins_cnt;
    reset = 1'b1;
    tick(15);
    checks++; if (ins_cnt - i0 !== 0) begin failures++; $display("FAIL mid_held got=%0d exp=0", ins_cnt - i0); end
    bus_if.key_insert_n = 1'b1;
    tick(10);
    press(1'b1, 1'b0, 4'd6);
    checks++; if (ins_cnt - i0 !== 1) begin failures++; $display("FAIL mid_repress got=%0d exp=1", ins_cnt - i0); end
    checks++; if (bus_if.digit_count !== 3'd1) begin failures++; $display("FAIL mid_repress_count got=%0d exp=1", bus_if.digit_count); end
    checks++; if (bus_if.num !== 4'd6) begin failures++; $display("FAIL mid_repress_num got=%0d exp=6", bus_if.num); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL strobe_excl got=%b exp=0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_sequence();
    test_early_finish();
    test_simultaneous();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lottery_input_ctrl.md
Name: lottery_input_ctrl

Overview:
- Front-end stage for the lottery game FSM.
- Conditions raw board switches and two push buttons: synchronises, debounces, edge-detects.
- Validates each digit and emits single-cycle insert/finish strobes plus a registered 4-bit digit for the game block's num/insert/finish inputs.
- Enforces the 5-digit entry sequence, so the game never sees extra inserts or a premature finish.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); must be at least 1.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- MAX_DIGITS, 5, digits collected before finish is accepted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sw  in  4  raw digit switches, asynchronous.
- key_insert_n  in  1  raw insert button, active-low, bouncy.
- key_finish_n  in  1  raw finish button, active-low, bouncy.
- num  out  4  registered accepted digit; valid in the insert cycle and held afterwards.
- insert  out  1  one-cycle strobe per accepted digit.
- finish  out  1  one-cycle strobe when the game is submitted.
- digit_count  out  3  digits accepted so far, 0..MAX_DIGITS.
- err  out  1  one-cycle strobe on any rejected press.
- locked  out  1  high after finish is issued.

Behaviour:
- Reset (reset=0, asynchronous):
  - num=0, insert=0, finish=0, digit_count=0, err=0, locked=0, state=COLLECT.
  - Synchroniser flops and debounced levels = 1 (released); debounce counters = 0.
  - Reset asserted mid-debounce or mid-entry discards everything; no strobe may appear in the cycle reset deasserts.
- Synchronisers: 2-flop synchroniser on each button and on each sw bit.
- Debounce (per button):
  - Counter increments while the synced level differs from the debounced level; it clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the debounced level flips and the counter clears.
- Press event: debounced level goes 1->0, registered as a one-cycle press flag.
  - Latency: the first edge sampling the raw pin low gives the press flag DEBOUNCE_CYCLES+2 cycles later; the output strobe follows 1 cycle after that (DEBOUNCE_CYCLES+3 total).
  - Release generates nothing.
  - A held button gives exactly one event.
- Digit validity: sw_sync <= 9 (subject to the Optional Feature).
- FSM states: COLLECT, FULL, LOCKED.
  - COLLECT, insert press with valid digit: num<=sw_sync, insert=1, digit_count+1. Go to FULL when the new count equals MAX_DIGITS.
  - COLLECT, insert press with invalid digit: err=1; num and count unchanged.
  - COLLECT, finish press: err=1; ignored.
  - FULL, insert press: err=1; num unchanged.
  - FULL, finish press: finish=1, locked=1 from the next cycle, go to LOCKED; digit_count stays MAX_DIGITS.
  - LOCKED: all presses ignored, err stays 0; exit only via reset.
- Simultaneous presses in the same cycle:
  - COLLECT: insert is processed, finish is dropped, err=1.
  - FULL: finish is processed, insert is dropped, no err.
  - insert and finish are never both 1.
- sw changing during a press: the value sampled (synced) in the press-flag cycle is used.
- digit_count saturates at MAX_DIGITS and never wraps.

Optional Feature:
- Macro: LOTTERY_DIGIT_FILTER_EN.
- Defined: digits 10..15 are rejected with err as above.
- Undefined: every 4-bit value is accepted and err fires only on sequence violations.

Test Plan:
- Sim uses DEBOUNCE_CYCLES=4. Release reset, press insert with sw=5 held 20 cycles -> exactly one insert strobe 7 cycles after the first low sample, num=5, digit_count=1.
- Bounce insert low/high every 2 cycles for 12 cycles, then hold low -> single insert strobe; no strobe during the bounce.
- Enter 5,0,9,6,7, then a 6th insert -> five insert strobes, digit_count=5, 6th gives err=1 with num still 7; finish -> finish=1 one cycle, locked=1.
- After 2 digits press finish -> err=1, no finish strobe, digit_count=2. With the filter enabled, insert with sw=12 -> err=1, count unchanged.
- Insert and finish debounced in the same cycle: at count=5 -> finish only; at count=3 -> insert only plus err.
- Pull reset low mid-debounce at count=3 -> all outputs 0 immediately; after release, still-held button produces no strobe until released and pressed again.
